// File: rtl/alu_nibble_serial.sv
// Nibble-serial 74181-style ALU: one 4-bit slice per clock, LSB slice first.
// Define ALU_FLAGS_EN to add the zero and ovf result flags.
module alu_nibble_serial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       select,
  input  logic             mode,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic             cout,
`ifdef ALU_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] f
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       sel_q, sel_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic [3:0] a4, b4, u, v, slice_f;
  logic [4:0] sum;
  logic       slice_c;

`ifdef ALU_FLAGS_EN
  logic       zero_q, zero_d, ovf_q, ovf_d;
  logic [3:0] lo;
  logic       slice_v;
`endif

  // 74181 slice as U plus V plus carry; the logic functions are ~(U ^ V).
  always_comb begin
    a4      = a_q[{idx_q, 2'b00} +: 4];
    b4      = b_q[{idx_q, 2'b00} +: 4];
    u       = a4 | (b4 & {4{sel_q[0]}}) | (~b4 & {4{sel_q[1]}});
    v       = (a4 & b4 & {4{sel_q[3]}}) | (a4 & ~b4 & {4{sel_q[2]}});
    sum     = {1'b0, u} + {1'b0, v} + {4'b0000, carry_q};
    slice_f = mode_q ? ~(u ^ v) : sum[3:0];
    slice_c = ~mode_q & sum[4];
  end

`ifdef ALU_FLAGS_EN
  // Carry into the slice MSB, needed for the signed overflow of the top slice.
  always_comb begin
    lo      = {1'b0, u[2:0]} + {1'b0, v[2:0]} + {3'b000, carry_q};
    slice_v = ~mode_q & (lo[3] ^ sum[4]);
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    res_d   = res_q;
    f_d     = f_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef ALU_FLAGS_EN
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sel_d   = select;
          mode_d  = mode;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[{idx_q, 2'b00} +: 4] = slice_f;
        carry_d = slice_c;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          f_d     = res_d;
          cout_d  = slice_c;
`ifdef ALU_FLAGS_EN
          zero_d  = (res_d == '0);
          ovf_d   = slice_v;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
`ifdef ALU_FLAGS_EN
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign cout = cout_q;
  assign f    = f_q;
`ifdef ALU_FLAGS_EN
  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_nibble_serial.sv
// Scoreboard bench for alu_nibble_serial (16- and 32-bit instances).
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu_nibble_serial;

  typedef struct {
    logic [31:0] f;
    logic        c;
    logic        z;
    logic        o;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start16 = 1'b0, mode16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  sel16 = '0;
  logic        busy16, done16, cout16;
  logic [15:0] f16;

  logic        start32 = 1'b0, mode32 = 1'b0, cin32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [3:0]  sel32 = '0;
  logic        busy32, done32, cout32;
  logic [31:0] f32;

`ifdef ALU_FLAGS_EN
  logic zero16, ovf16, zero32, ovf32;
`endif

  always #5 clk = ~clk;

  alu_nibble_serial #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .select(sel16), .mode(mode16), .cin(cin16),
    .busy(busy16), .done(done16), .cout(cout16),
`ifdef ALU_FLAGS_EN
    .zero(zero16), .ovf(ovf16),
`endif
    .f(f16)
  );

  alu_nibble_serial #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .select(sel32), .mode(mode32), .cin(cin32),
    .busy(busy32), .done(done32), .cout(cout32),
`ifdef ALU_FLAGS_EN
    .zero(zero32), .ovf(ovf32),
`endif
    .f(f32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the oldest expectation whenever a DUT completes.
  always @(negedge clk) begin
    if (!rst && done16) begin
      check("sb16_has_entry", 64'(q16.size() != 0), 64'd1);
      if (q16.size() != 0) begin
        exp_t e;
        e = q16.pop_front();
        check("f16", 64'(f16), 64'(e.f[15:0]));
        check("cout16", 64'(cout16), 64'(e.c));
`ifdef ALU_FLAGS_EN
        check("zero16", 64'(zero16), 64'(e.z));
        check("ovf16", 64'(ovf16), 64'(e.o));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done32) begin
      check("sb32_has_entry", 64'(q32.size() != 0), 64'd1);
      if (q32.size() != 0) begin
        exp_t e;
        e = q32.pop_front();
        check("f32", 64'(f32), 64'(e.f));
        check("cout32", 64'(cout32), 64'(e.c));
`ifdef ALU_FLAGS_EN
        check("zero32", 64'(zero32), 64'(e.z));
        check("ovf32", 64'(ovf32), 64'(e.o));
`endif
      end
    end
  end

  // Called before a rising edge; returns #1 after the edge that samples start.
  task automatic issue16(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] is,
                         input logic im, input logic ic, input logic [15:0] ef,
                         input logic ec, input logic ez, input logic eo, input bit push);
    a16 = ia; b16 = ib; sel16 = is; mode16 = im; cin16 = ic; start16 = 1'b1;
    if (push) q16.push_back('{f: 32'(ef), c: ec, z: ez, o: eo});
    @(posedge clk);
    #1;
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); sel16 = 4'($urandom);
    mode16 = 1'($urandom); cin16 = 1'($urandom);
  endtask

  // Returns at the falling edge where done is seen; lat = edges after the call point.
  task automatic wait_done16(output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (done16) begin
        lat = k;
        return;
      end
      if (busy16) bc++;
    end
  endtask

  task automatic wait_done32(output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (done32) begin
        lat = k;
        return;
      end
      if (busy32) bc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, ndone, nbusy;

    #1;
    check("rst_busy16", 64'(busy16), 64'd0);
    check("rst_done16", 64'(done16), 64'd0);
    check("rst_f16", 64'(f16), 64'd0);
    check("rst_cout16", 64'(cout16), 64'd0);
    check("rst_f32", 64'(f32), 64'd0);
`ifdef ALU_FLAGS_EN
    check("rst_zero16", 64'(zero16), 64'd1);
    check("rst_ovf16", 64'(ovf16), 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Plain add with latency, busy length and single-cycle done.
    issue16(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done16(lat, bc);
    check("lat_add", 64'(lat), 64'd4);
    check("busy_add", 64'(bc), 64'd4);
    @(negedge clk);
    check("done_one_cycle", 64'(done16), 64'd0);

    issue16(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_done16(lat, bc);
    check("lat_wrap", 64'(lat), 64'd4);
    @(negedge clk);

    // Signed overflow, then a logic op issued on the done cycle.
    issue16(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done16(lat, bc);
    issue16(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done16(lat, bc);
    check("lat_b2b", 64'(lat), 64'd4);
    @(negedge clk);

    issue16(16'h5000, 16'h1000, 4'b0110, 1'b0, 1'b1, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_done16(lat, bc);
    @(negedge clk);
    issue16(16'h0F0F, 16'h00FF, 4'b1011, 1'b1, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done16(lat, bc);
    @(negedge clk);

    // Start while busy is ignored; f holds the previous result meanwhile.
    issue16(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("f_hold", 64'(f16), 64'h000F);
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; sel16 = 4'b0110; mode16 = 1'b1; start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    wait_done16(lat, bc);
    check("lat_ignored_start", 64'(lat), 64'd2);
    @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    issue16(16'h0003, 16'h0004, 4'b1001, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_f", 64'(f16), 64'd0);
    check("abort_busy", 64'(busy16), 64'd0);
    check("abort_done", 64'(done16), 64'd0);
    check("abort_cout", 64'(cout16), 64'd0);
`ifdef ALU_FLAGS_EN
    check("abort_zero", 64'(zero16), 64'd1);
    check("abort_ovf", 64'(ovf16), 64'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    nbusy = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done16) ndone++;
      if (busy16) nbusy++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_no_busy", 64'(nbusy), 64'd0);

    // 32-bit instance: full carry ripple across eight slices.
    a32 = 32'hFFFF_FFFF; b32 = 32'h0; sel32 = 4'b1001; mode32 = 1'b0; cin32 = 1'b1;
    start32 = 1'b1;
    q32.push_back('{f: 32'h0000_0000, c: 1'b1, z: 1'b1, o: 1'b0});
    @(posedge clk);
    #1;
    start32 = 1'b0;
    a32 = $urandom; b32 = $urandom; cin32 = 1'b0;
    wait_done32(lat, bc);
    check("lat32", 64'(lat), 64'd8);
    check("busy32", 64'(bc), 64'd8);
    @(negedge clk);
    @(negedge clk);

    check("sb16_drained", 64'(q16.size()), 64'd0);
    check("sb32_drained", 64'(q32.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
